// File: rtl/mem_ring_pkg.sv
// Shared definitions for the memory-side ring endpoint.
//   - Width localparams for address, data, requester id and packet type.
//   - pkt_type_t: ring packet type codes. Codes not listed here are
//     foreign traffic and pass through the endpoint untouched.
//   - ring_pkt_t: one ring slot {type, id, addr, data}.
//   - ctrl_state_t: controller FSM state, exported for debug.
package mem_ring_pkg;

  localparam int MR_ADDR_W = 36;
  localparam int MR_DATA_W = 512;
  localparam int MR_ID_W   = 4;
  localparam int MR_PT_W   = 3;

  typedef enum logic [MR_PT_W-1:0] {
    PKT_EMPTY   = 3'b000,
    PKT_WR_REQ  = 3'b001,
    PKT_RD_REQ  = 3'b011,
    PKT_WR_ACK  = 3'b101,
    PKT_RD_RESP = 3'b110
  } pkt_type_t;

  typedef struct packed {
    logic [MR_PT_W-1:0]   ptype;
    logic [MR_ID_W-1:0]   id;
    logic [MR_ADDR_W-1:0] addr;
    logic [MR_DATA_W-1:0] data;
  } ring_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HAL_WR  = 2'd1,
    ST_HAL_RD  = 2'd2,
    ST_RESPOND = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/ring_mem_controller.sv
// Memory-side endpoint of the request ring. Takes one WR_REQ/RD_REQ
// from its ring slot at a time, runs it against the HAL read or write
// port, then injects WR_ACK / RD_RESP into the first EMPTY slot that
// passes, addressed to the original requester id.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   *_req_in, addr_in,
//   data_in                  packet currently in this node's ring slot
//   overwrite, *_out         replace-slot request and packet to inject;
//                            combinational, registered by the ring stage
//   rd_go/rd_en/rd_addr/
//   cache_lines              HAL read request side
//   rd_data/rd_done/empty    HAL read completion and stall
//   wr_go/wr_en/wr_addr/
//   wr_data/wr_size          HAL write request side
//   wr_done/full             HAL write completion and stall
//   dbg_state                current FSM state
//
// HAL handshake: a go signal is a level request held from the cycle
// after capture until its done pulse is accepted. A done pulse is
// accepted only in the matching HAL state and only while the matching
// stall input (full / empty) is low; in all other cycles the request
// and its address/data are held unchanged.
module ring_mem_controller
  import mem_ring_pkg::*;
#(
  parameter int ADDR_W = MR_ADDR_W,
  parameter int DATA_W = MR_DATA_W,
  parameter int ID_W   = MR_ID_W,
  parameter int PT_W   = MR_PT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PT_W-1:0]   packet_type_req_in,
  input  logic [ID_W-1:0]   id_req_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              overwrite,
  output logic [PT_W-1:0]   packet_type_req_out,
  output logic [ID_W-1:0]   id_req_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_go,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       cache_lines,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  input  logic              empty,
  output logic              wr_go,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       wr_size,
  input  logic              wr_done,
  input  logic              full,
  output ctrl_state_t       dbg_state
);

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [ID_W-1:0]   lat_id;
  logic              lat_is_wr;
  logic [PT_W-1:0]   resp_type;
  logic [DATA_W-1:0] resp_data;
  logic              wr_first;

  logic slot_wr_req;
  logic slot_rd_req;
  logic slot_empty;
  logic wr_accept;
  logic rd_accept;

  assign slot_wr_req = (packet_type_req_in == PKT_WR_REQ);
  assign slot_rd_req = (packet_type_req_in == PKT_RD_REQ);
  assign slot_empty  = (packet_type_req_in == PKT_EMPTY);
  assign wr_accept   = (state == ST_HAL_WR) && wr_done && !full;
  assign rd_accept   = (state == ST_HAL_RD) && rd_done && !empty;

  // State register plus request / response latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_id    <= '0;
      lat_is_wr <= 1'b0;
      resp_type <= '0;
      resp_data <= '0;
      wr_first  <= 1'b0;
    end else begin
      state    <= state_next;
      // wr_en marks only the first cycle of a write request.
      wr_first <= (state == ST_IDLE) && slot_wr_req;
      if (state == ST_IDLE && (slot_wr_req || slot_rd_req)) begin
        lat_addr  <= addr_in;
        lat_data  <= data_in;
        lat_id    <= id_req_in;
        lat_is_wr <= slot_wr_req;
      end
      if (wr_accept && lat_is_wr) begin
        resp_type <= PKT_WR_ACK;
        resp_data <= '0;
      end
      if (rd_accept && !lat_is_wr) begin
        resp_type <= PKT_RD_RESP;
        resp_data <= rd_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (slot_wr_req)      state_next = ST_HAL_WR;
        else if (slot_rd_req) state_next = ST_HAL_RD;
      end
      ST_HAL_WR:  if (wr_accept)  state_next = ST_RESPOND;
      ST_HAL_RD:  if (rd_accept)  state_next = ST_RESPOND;
      ST_RESPOND: if (slot_empty) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs. Captures free the slot by writing an all-zero EMPTY packet;
  // injections only ever land on an EMPTY slot, so foreign traffic and
  // requests arriving while busy are never disturbed.
  always_comb begin
    overwrite           = 1'b0;
    packet_type_req_out = '0;
    id_req_out          = '0;
    addr_out            = '0;
    data_out            = '0;
    rd_go               = 1'b0;
    rd_en               = 1'b0;
    rd_addr             = '0;
    wr_go               = 1'b0;
    wr_en               = 1'b0;
    wr_addr             = '0;
    wr_data             = '0;
    case (state)
      ST_IDLE: begin
        if (slot_wr_req || slot_rd_req) overwrite = 1'b1;
      end
      ST_HAL_WR: begin
        wr_go   = 1'b1;
        wr_en   = wr_first;
        wr_addr = lat_addr;
        wr_data = lat_data;
      end
      ST_HAL_RD: begin
        rd_go   = 1'b1;
        rd_en   = rd_accept;
        rd_addr = lat_addr;
      end
      ST_RESPOND: begin
        if (slot_empty) begin
          overwrite           = 1'b1;
          packet_type_req_out = resp_type;
          id_req_out          = lat_id;
          addr_out            = lat_addr;
          data_out            = resp_data;
        end
      end
      default: ;
    endcase
  end

  assign cache_lines = 16'd1;
  assign wr_size     = 16'd1;
  assign dbg_state   = state;

endmodule

// File: tb/tb_ring_mem_controller.sv
// Directed bench for ring_mem_controller. Inputs change 1 time unit
// after the rising edge; combinational outputs are sampled 1 unit
// later, registered state is sampled after the following edge.
module tb_ring_mem_controller;
  import mem_ring_pkg::*;

  logic         clk;
  logic         rst;
  logic [2:0]   packet_type_req_in;
  logic [3:0]   id_req_in;
  logic [35:0]  addr_in;
  logic [511:0] data_in;
  logic         overwrite;
  logic [2:0]   packet_type_req_out;
  logic [3:0]   id_req_out;
  logic [35:0]  addr_out;
  logic [511:0] data_out;
  logic         rd_go;
  logic         rd_en;
  logic [35:0]  rd_addr;
  logic [15:0]  cache_lines;
  logic [511:0] rd_data;
  logic         rd_done;
  logic         empty;
  logic         wr_go;
  logic         wr_en;
  logic [35:0]  wr_addr;
  logic [511:0] wr_data;
  logic [15:0]  wr_size;
  logic         wr_done;
  logic         full;
  ctrl_state_t  dbg_state;

  int n_vec;
  int n_miss;

  ring_mem_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .packet_type_req_in  (packet_type_req_in),
    .id_req_in           (id_req_in),
    .addr_in             (addr_in),
    .data_in             (data_in),
    .overwrite           (overwrite),
    .packet_type_req_out (packet_type_req_out),
    .id_req_out          (id_req_out),
    .addr_out            (addr_out),
    .data_out            (data_out),
    .rd_go               (rd_go),
    .rd_en               (rd_en),
    .rd_addr             (rd_addr),
    .cache_lines         (cache_lines),
    .rd_data             (rd_data),
    .rd_done             (rd_done),
    .empty               (empty),
    .wr_go               (wr_go),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_size             (wr_size),
    .wr_done             (wr_done),
    .full                (full),
    .dbg_state           (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [2:0] t, input logic [3:0] id,
                      input logic [35:0] a, input logic [511:0] d);
    packet_type_req_in = t;
    id_req_in          = id;
    addr_in            = a;
    data_in            = d;
  endtask

  task automatic check_out(input string tag, input logic ow,
                           input logic [2:0] t, input logic [3:0] id,
                           input logic [35:0] a, input logic [511:0] d);
    check({tag, ".ow"},   {511'd0, overwrite}, {511'd0, ow});
    check({tag, ".type"}, {509'd0, packet_type_req_out}, {509'd0, t});
    check({tag, ".id"},   {508'd0, id_req_out}, {508'd0, id});
    check({tag, ".addr"}, {476'd0, addr_out}, {476'd0, a});
    check({tag, ".data"}, data_out, d);
  endtask

  task automatic check_state(input string tag, input logic [1:0] s);
    check(tag, {510'd0, dbg_state}, {510'd0, s});
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    slot(3'b000, 4'd0, 36'd0, 512'd0);
    rd_data = '0; rd_done = 1'b0; empty = 1'b0;
    wr_done = 1'b0; full = 1'b0;

    // reset
    tick(); tick();
    check_state("rst.state", 2'd0);
    check("rst.rd_go", {511'd0, rd_go}, 512'd0);
    check("rst.wr_go", {511'd0, wr_go}, 512'd0);
    check("rst.cache_lines", {496'd0, cache_lines}, 512'd1);
    check("rst.wr_size", {496'd0, wr_size}, 512'd1);
    rst = 1'b0;
    tick();
    check_out("idle_empty", 1'b0, 3'd0, 4'd0, 36'd0, 512'd0);

    // write request: capture, HAL write, ack
    slot(3'b001, 4'd3, 36'h12345, 512'hAB);
    #1;
    check_out("wr.cap", 1'b1, 3'd0, 4'd0, 36'd0, 512'd0);
    tick();
    slot(3'b000, 4'd0, 36'd0, 512'd0);
    #1;
    check_state("wr.state", 2'd1);
    check("wr.go", {511'd0, wr_go}, 512'd1);
    check("wr.en0", {511'd0, wr_en}, 512'd1);
    check("wr.addr", {476'd0, wr_addr}, 512'h12345);
    check("wr.data", wr_data, 512'hAB);
    check("wr.ow_busy", {511'd0, overwrite}, 512'd0);
    tick();
    check("wr.en1", {511'd0, wr_en}, 512'd0);
    check("wr.go1", {511'd0, wr_go}, 512'd1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    check_state("wr.resp_state", 2'd3);
    check("wr.go_drop", {511'd0, wr_go}, 512'd0);
    check_out("wr.ack", 1'b1, 3'b101, 4'd3, 36'h12345, 512'd0);
    tick();
    check_state("wr.back_idle", 2'd0);

    // read request with HAL stall and busy ring
    slot(3'b011, 4'd7, 36'h40, 512'd0);
    #1;
    check_out("rd.cap", 1'b1, 3'd0, 4'd0, 36'd0, 512'd0);
    tick();
    slot(3'b010, 4'd2, 36'h999, 512'h77);
    #1;
    check_state("rd.state", 2'd2);
    check("rd.go", {511'd0, rd_go}, 512'd1);
    check("rd.addr", {476'd0, rd_addr}, 512'h40);
    check("rd.ow_foreign", {511'd0, overwrite}, 512'd0);
    empty = 1'b1; rd_data = 512'h40; rd_done = 1'b1;
    #1;
    check("rd.en_stalled", {511'd0, rd_en}, 512'd0);
    tick();
    check_state("rd.stall_hold", 2'd2);
    check("rd.go_hold", {511'd0, rd_go}, 512'd1);
    empty = 1'b0;
    #1;
    check("rd.en", {511'd0, rd_en}, 512'd1);
    tick();
    rd_done = 1'b0; rd_data = '0;
    #1;
    check_state("rd.resp_state", 2'd3);
    check("rd.go_drop", {511'd0, rd_go}, 512'd0);
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("rd.busy%0d", i), 1'b0, 3'd0, 4'd0, 36'd0, 512'd0);
      tick();
      if (i == 2) begin
        slot(3'b011, 4'd5, 36'h55, 512'd0);
        #1;
      end
    end
    slot(3'b000, 4'd0, 36'd0, 512'd0);
    #1;
    check_out("rd.resp", 1'b1, 3'b110, 4'd7, 36'h40, 512'h40);
    tick();
    check_state("rd.back_idle", 2'd0);

    // write stalled by full; foreign RD_REQ passes untouched
    slot(3'b001, 4'd1, 36'h100, 512'h55);
    #1;
    check("wf.cap", {511'd0, overwrite}, 512'd1);
    tick();
    full = 1'b1;
    slot(3'b011, 4'd9, 36'h200, 512'd0);
    for (int i = 0; i < 10; i++) begin
      wr_done = (i == 5);
      rd_done = (i == 6);
      #1;
      check($sformatf("wf.ow%0d", i), {511'd0, overwrite}, 512'd0);
      check($sformatf("wf.go%0d", i), {511'd0, wr_go}, 512'd1);
      check($sformatf("wf.addr%0d", i), {476'd0, wr_addr}, 512'h100);
      check($sformatf("wf.rden%0d", i), {511'd0, rd_en}, 512'd0);
      tick();
    end
    wr_done = 1'b0; rd_done = 1'b0;
    check_state("wf.still_wr", 2'd1);
    full = 1'b0;
    slot(3'b000, 4'd0, 36'd0, 512'd0);
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #1;
    check_out("wf.ack", 1'b1, 3'b101, 4'd1, 36'h100, 512'd0);
    tick();
    check_state("wf.back_idle", 2'd0);

    // the circulating RD_REQ is accepted on a later pass
    slot(3'b011, 4'd9, 36'h200, 512'd0);
    #1;
    check("late.cap", {511'd0, overwrite}, 512'd1);
    tick();
    slot(3'b000, 4'd0, 36'd0, 512'd0);
    #1;
    check_state("late.state", 2'd2);
    check("late.addr", {476'd0, rd_addr}, 512'h200);

    // reset mid-read abandons it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rr.rd_go", {511'd0, rd_go}, 512'd0);
    check_state("rr.state", 2'd0);
    rd_data = 512'hDEAD;
    for (int i = 0; i < 4; i++) begin
      rd_done = (i == 1);
      #1;
      check($sformatf("rr.ow%0d", i), {511'd0, overwrite}, 512'd0);
      check($sformatf("rr.idle%0d", i), {510'd0, dbg_state}, 512'd0);
      tick();
    end
    rd_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
